// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem request/response credit, fetch buffer, redirect flush.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (sticky misalign_err, halts fetch on misaligned redirect).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] ghost_q, ghost_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   fpc_q  [DEPTH];
  logic [31:0]   fpc_d  [DEPTH];
  logic [31:0]   pcq_q  [DEPTH];
  logic [31:0]   pcq_d  [DEPTH];
  logic [CW:0]   credit_used;
  logic          halted;
  logic          accept, rsp_ghost, rsp_drop, rsp_keep, pop;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic err_q, err_d;
  assign halted       = err_q;
  assign misalign_err = err_q;
`else
  assign halted = 1'b0;
`endif

  // Credits cover both buffered words and requests still out at memory.
  always_comb begin
    credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req_valid = (state_q == RUN) && (credit_used < {1'b0, DEPTH_C}) &&
                     (drop_q == '0) && (ghost_q == '0) && !branch_taken && !halted;
  end

  assign imem_req_addr = pc_q;
  assign inst_valid    = (count_q != '0);
  assign instruction   = data_q[rd_ptr_q];
  assign pc_out        = fpc_q[rd_ptr_q];

  always_comb begin
    accept    = imem_req_valid && imem_req_ready;
    // ghost_q counts responses to requests issued before the last reset.
    rsp_ghost = imem_rsp_valid && (ghost_q != '0);
    rsp_drop  = imem_rsp_valid && (ghost_q == '0) && (drop_q != '0);
    rsp_keep  = imem_rsp_valid && (ghost_q == '0) && (drop_q == '0);
    pop       = inst_valid && inst_ready;

    state_d    = RUN;
    pc_d       = pc_q;
    drop_d     = drop_q;
    ghost_d    = ghost_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    data_d     = data_q;
    fpc_d      = fpc_q;
    pcq_d      = pcq_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    err_d      = err_q;
`endif

    if (accept) begin
      pcq_d[pcq_wr_q] = pc_q;
      pcq_wr_d        = pcq_wr_q + PW'(1);
      pc_d            = pc_q + 32'd4;
    end

    inflight_d = inflight_q + CW'(accept) - CW'(rsp_drop || rsp_keep);
    if (rsp_drop || rsp_keep) begin
      pcq_rd_d = pcq_rd_q + PW'(1);
    end
    if (rsp_ghost) begin
      ghost_d = ghost_q - CW'(1);
    end
    if (rsp_drop) begin
      drop_d = drop_q - CW'(1);
    end
    if (rsp_keep) begin
      data_d[wr_ptr_q] = imem_rsp_data;
      fpc_d[wr_ptr_q]  = pcq_q[pcq_rd_q];
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(rsp_keep) - CW'(pop);

    // Redirect: everything still outstanding after this edge is wrong-path.
    if (branch_taken) begin
      pc_d     = branch_target & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = inflight_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (branch_target[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
`endif
    end

    outstanding_d = ghost_d + inflight_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      ghost_q    <= outstanding_d;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        fpc_q[i]  <= '0;
        pcq_q[i]  <= '0;
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ghost_q    <= ghost_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      data_q     <= data_d;
      fpc_q      <= fpc_d;
      pcq_q      <= pcq_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule
